// File: rtl/top_pkg.sv
// Shared constants for the RV32I core and its unified instruction/data memory.
package top_pkg;
    localparam int unsigned RAM_WORD_CNT = 1024;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;

    // Fetched-word conventions used by simulation images to report status.
    localparam logic [31:0] ASSERT_SUCCESS    = 32'h0000_0001;
    localparam logic [31:0] ASSERT_FAIL       = 32'h0000_0000;
    localparam logic [31:0] ASSERT_TIMEOUT    = 32'h0000_0002;
    localparam logic [31:0] ASSERT_DEBUG_STOP = 32'h0000_0003;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        CORE_RUN  = 1'b0,
        CORE_HALT = 1'b1
    } core_state_e;

    // Byte-lane enables for a store of the given size (funct3[1:0]) at a byte offset.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction
endpackage

// File: rtl/top_if.sv
// Core-to-memory bus: instruction fetch port plus byte-masked data port.
interface top_if;
    logic [31:0] i_addr;
    logic [31:0] i_read;
    logic [31:0] d_addr;
    logic [31:0] d_write;
    logic        d_we;
    logic [3:0]  d_mask;
    logic [31:0] d_read;

    modport master (output i_addr, d_addr, d_write, d_we, d_mask, input i_read, d_read);
    modport slave  (input i_addr, d_addr, d_write, d_we, d_mask, output i_read, d_read);
endinterface

// File: rtl/cpu.sv
// Single-cycle RV32I core: one instruction fetched, executed and retired per clock.
// Unknown opcodes halt the core at the offending pc until the next reset.
module cpu #(
    parameter logic [31:0] RESET_PC = top_pkg::RESET_PC
) (
    input logic    clk,
    input logic    reset,
    top_if.master  bus
);
    import top_pkg::*;

    core_state_e state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic [31:0] rf [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, op_b, alu_y, load_v, wb_v, d_addr_v;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        wb_en, take, st_en;

    assign instr  = bus.i_read;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_v    = rf[rs1];
    assign rs2_v    = rf[rs2];
    assign op_b     = (opcode == OP_REG) ? rs2_v : imm_i;
    assign pc_plus4 = pc + 32'd4;
    assign d_addr_v = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);

    always_comb begin
        alu_y = '0;
        case (f3)
            F3_ADD:  alu_y = (opcode == OP_REG && instr[30]) ? rs1_v - op_b : rs1_v + op_b;
            F3_SLL:  alu_y = rs1_v << op_b[4:0];
            F3_SLT:  alu_y = {31'b0, $signed(rs1_v) < $signed(op_b)};
            F3_SLTU: alu_y = {31'b0, rs1_v < op_b};
            F3_XOR:  alu_y = rs1_v ^ op_b;
            F3_SR:   alu_y = instr[30] ? $unsigned($signed(rs1_v) >>> op_b[4:0])
                                       : rs1_v >> op_b[4:0];
            F3_OR:   alu_y = rs1_v | op_b;
            F3_AND:  alu_y = rs1_v & op_b;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (f3)
            F3_BEQ:  take = (rs1_v == rs2_v);
            F3_BNE:  take = (rs1_v != rs2_v);
            F3_BLT:  take = ($signed(rs1_v) < $signed(rs2_v));
            F3_BGE:  take = ($signed(rs1_v) >= $signed(rs2_v));
            F3_BLTU: take = (rs1_v < rs2_v);
            F3_BGEU: take = (rs1_v >= rs2_v);
            default: take = 1'b0;
        endcase
    end

    assign ld_byte = bus.d_read[{d_addr_v[1:0], 3'b000} +: 8];
    assign ld_half = bus.d_read[{d_addr_v[1], 4'b0000} +: 16];

    always_comb begin
        load_v = bus.d_read;
        case (f3[1:0])
            2'b00:   load_v = {{24{ld_byte[7] & ~f3[2]}}, ld_byte};
            2'b01:   load_v = {{16{ld_half[15] & ~f3[2]}}, ld_half};
            default: load_v = bus.d_read;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_plus4;
        wb_en     = 1'b0;
        wb_v      = alu_y;
        st_en     = 1'b0;
        if (state == CORE_HALT) begin
            pc_nxt = pc;
        end else begin
            case (opcode)
                OP_LUI:    begin wb_en = 1'b1; wb_v = imm_u; end
                OP_AUIPC:  begin wb_en = 1'b1; wb_v = pc + imm_u; end
                OP_JAL:    begin wb_en = 1'b1; wb_v = pc_plus4; pc_nxt = pc + imm_j; end
                OP_JALR:   begin wb_en = 1'b1; wb_v = pc_plus4; pc_nxt = (rs1_v + imm_i) & ~32'd1; end
                OP_BRANCH: if (take) pc_nxt = pc + imm_b;
                OP_LOAD:   begin wb_en = 1'b1; wb_v = load_v; end
                OP_STORE:  st_en = 1'b1;
                OP_IMM, OP_REG: wb_en = 1'b1;
                OP_FENCE:  ;
                default:   begin state_nxt = CORE_HALT; pc_nxt = pc; end
            endcase
        end
    end

    assign bus.i_addr  = pc;
    assign bus.d_addr  = d_addr_v;
    assign bus.d_we    = st_en & ~reset;
    assign bus.d_mask  = store_mask(f3[1:0], d_addr_v[1:0]);
    assign bus.d_write = (f3[1:0] == 2'b00) ? {4{rs2_v[7:0]}} :
                         (f3[1:0] == 2'b01) ? {2{rs2_v[15:0]}} : rs2_v;

    always_ff @(posedge clk) begin
        if (reset) state <= CORE_RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            for (int unsigned r = 0; r < 32; r++) rf[r] <= '0;
        end else begin
            pc <= pc_nxt;
            if (wb_en && rd != 5'd0) rf[rd] <= wb_v;
        end
    end
endmodule

// File: rtl/top_ram.sv
// Unified word RAM: async read on both ports, synchronous byte-masked write on the data port.
module ram #(
    parameter int unsigned WORD_CNT = top_pkg::RAM_WORD_CNT
) (
    input logic   clk,
    top_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(WORD_CNT);

    logic [31:0]      ram [WORD_CNT];
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;
    logic             addr_unused;

    // Upper address bits are dropped, so the array aliases across the address space.
    assign i_idx = bus.i_addr[IDX_W+1:2];
    assign d_idx = bus.d_addr[IDX_W+1:2];
    assign addr_unused = ^{bus.i_addr[31:IDX_W+2], bus.i_addr[1:0],
                           bus.d_addr[31:IDX_W+2], bus.d_addr[1:0]};

    assign bus.i_read = ram[i_idx];
    assign bus.d_read = ram[d_idx];

    always_ff @(posedge clk) begin
        if (bus.d_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (bus.d_mask[k]) begin
                    ram[d_idx][8*k +: 8] <= bus.d_write[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/top.sv
// RV32I system: core plus unified RAM, with the bus exposed as named nets for probing.
module top #(
    parameter int unsigned RAM_WORD_CNT = top_pkg::RAM_WORD_CNT,
    parameter logic [31:0] RESET_PC     = top_pkg::RESET_PC
) (
    input logic clk,
    input logic reset
);
    logic [31:0] i_addr, i_read, d_addr, d_write, d_read;
    logic        d_we;
    logic [3:0]  d_mask;

    top_if bus_c ();
    top_if bus_r ();

    // Two bus instances joined through the named nets so every net has a reader.
    assign i_addr  = bus_c.i_addr;
    assign d_addr  = bus_c.d_addr;
    assign d_write = bus_c.d_write;
    assign d_we    = bus_c.d_we;
    assign d_mask  = bus_c.d_mask;
    assign i_read  = bus_r.i_read;
    assign d_read  = bus_r.d_read;

    assign bus_r.i_addr  = i_addr;
    assign bus_r.d_addr  = d_addr;
    assign bus_r.d_write = d_write;
    assign bus_r.d_we    = d_we;
    assign bus_r.d_mask  = d_mask;
    assign bus_c.i_read  = i_read;
    assign bus_c.d_read  = d_read;

    cpu #(.RESET_PC(RESET_PC)) cpu (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_c)
    );

    ram #(.WORD_CNT(RAM_WORD_CNT)) ram (
        .clk (clk),
        .bus (bus_r)
    );
endmodule

// File: tb/tb_top.sv
// Directed-program bench for the RV32I system: preloads images into RAM and checks fetch, store and reset behaviour.
module tb_top;
    import top_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    top dut (
        .clk   (clk),
        .reset (reset)
    );

    top_if probe ();
    assign probe.i_addr  = dut.i_addr;
    assign probe.i_read  = dut.i_read;
    assign probe.d_addr  = dut.d_addr;
    assign probe.d_write = dut.d_write;
    assign probe.d_we    = dut.d_we;
    assign probe.d_mask  = dut.d_mask;
    assign probe.d_read  = dut.d_read;

    initial forever #5 clk = ~clk;

    task automatic begin_test();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < RAM_WORD_CNT; i++) dut.ram.ram[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        begin_test();
        dut.ram.ram[0] = ASSERT_SUCCESS;
        vectors++;
        if (probe.d_we !== 1'b0) begin miscompares++; $display("FAIL reset_dwe: got %b want 0", probe.d_we); end
        release_reset();
        vectors++;
        if (dut.cpu.pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", dut.cpu.pc); end
        vectors++;
        if (probe.i_read !== 32'h1) begin miscompares++; $display("FAIL reset_first_fetch: got %h want 00000001", probe.i_read); end
        repeat (3) @(negedge clk);
        vectors++;
        if (probe.i_addr !== 32'h0) begin miscompares++; $display("FAIL reset_halt_pc: got %h want 00000000", probe.i_addr); end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [6] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h10, 32'h10};
        logic saw_fail = 1'b0;
        begin_test();
        dut.ram.ram[0] = 32'h00500093;  // addi x1,x0,5
        dut.ram.ram[1] = 32'hFFB08113;  // addi x2,x1,-5
        dut.ram.ram[2] = 32'h00010463;  // beq x2,x0,+8
        dut.ram.ram[3] = ASSERT_FAIL;
        dut.ram.ram[4] = ASSERT_SUCCESS;
        release_reset();
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (dut.cpu.pc !== exp_pc[c]) begin
                miscompares++; $display("FAIL branch_pc%0d: got %h want %h", c, dut.cpu.pc, exp_pc[c]);
            end
            if (probe.i_read === 32'h0) saw_fail = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_fail !== 1'b0) begin miscompares++; $display("FAIL branch_fail_word: got fetched, want never"); end
        vectors++;
        if (probe.i_read !== 32'h1) begin miscompares++; $display("FAIL branch_pass_word: got %h want 00000001", probe.i_read); end
        vectors++;
        if (dut.cpu.rf[1] !== 32'd5) begin miscompares++; $display("FAIL branch_x1: got %h want 00000005", dut.cpu.rf[1]); end
    endtask

    task automatic load_store_prog();
        dut.ram.ram[0] = 32'h123450B7;  // lui  x1,0x12345
        dut.ram.ram[1] = 32'h67808093;  // addi x1,x1,0x678
        dut.ram.ram[2] = 32'h10102023;  // sw   x1,0x100(x0)
        dut.ram.ram[3] = 32'h10002103;  // lw   x2,0x100(x0)
        dut.ram.ram[4] = 32'h00110463;  // beq  x2,x1,+8
        dut.ram.ram[5] = ASSERT_FAIL;
        dut.ram.ram[6] = ASSERT_SUCCESS;
    endtask

    task automatic test_store_load();
        begin_test();
        load_store_prog();
        release_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (probe.d_we !== 1'b1 || probe.d_mask !== 4'hF) begin
            miscompares++; $display("FAIL sw_strobe: got we=%b mask=%h want we=1 mask=f", probe.d_we, probe.d_mask);
        end
        vectors++;
        if (probe.d_read !== 32'h0) begin miscompares++; $display("FAIL sw_old_read: got %h want 00000000", probe.d_read); end
        @(negedge clk);
        vectors++;
        if (dut.ram.ram[64] !== 32'h12345678) begin miscompares++; $display("FAIL sw_commit: got %h want 12345678", dut.ram.ram[64]); end
        repeat (5) @(negedge clk);
        vectors++;
        if (dut.cpu.rf[2] !== 32'h12345678) begin miscompares++; $display("FAIL lw_x2: got %h want 12345678", dut.cpu.rf[2]); end
        vectors++;
        if (dut.cpu.pc !== 32'h18 || probe.i_read !== 32'h1) begin
            miscompares++; $display("FAIL lw_pass: got pc=%h word=%h want pc=00000018 word=00000001", dut.cpu.pc, probe.i_read);
        end
    endtask

    task automatic test_byte_store();
        begin_test();
        dut.ram.ram[0]  = 32'h100000A3;  // sb x0,0x101(x0)
        dut.ram.ram[1]  = ASSERT_SUCCESS;
        dut.ram.ram[63] = 32'hA5A5A5A5;
        dut.ram.ram[64] = 32'hFFFFFFFF;
        dut.ram.ram[65] = 32'h5A5A5A5A;
        release_reset();
        vectors++;
        if (probe.d_mask !== 4'b0010) begin miscompares++; $display("FAIL sb_mask: got %b want 0010", probe.d_mask); end
        repeat (3) @(negedge clk);
        vectors++;
        if (dut.ram.ram[64] !== 32'hFFFF00FF) begin miscompares++; $display("FAIL sb_lane: got %h want ffff00ff", dut.ram.ram[64]); end
        vectors++;
        if (dut.ram.ram[63] !== 32'hA5A5A5A5 || dut.ram.ram[65] !== 32'h5A5A5A5A) begin
            miscompares++; $display("FAIL sb_neighbours: got %h %h want a5a5a5a5 5a5a5a5a", dut.ram.ram[63], dut.ram.ram[65]);
        end
        vectors++;
        if (dut.ram.ram[0] !== 32'h100000A3) begin miscompares++; $display("FAIL sb_code_word: got %h want 100000a3", dut.ram.ram[0]); end
    endtask

    task automatic test_reset_midrun();
        begin_test();
        load_store_prog();
        release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (probe.d_we !== 1'b0) begin miscompares++; $display("FAIL mid_dwe_gated: got %b want 0", probe.d_we); end
        @(negedge clk);
        vectors++;
        if (dut.ram.ram[64] !== 32'h0) begin miscompares++; $display("FAIL mid_store_blocked: got %h want 00000000", dut.ram.ram[64]); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (dut.cpu.pc !== 32'h0) begin miscompares++; $display("FAIL mid_pc: got %h want 00000000", dut.cpu.pc); end
        vectors++;
        if (dut.ram.ram[64] !== 32'h12345678) begin miscompares++; $display("FAIL mid_mem_kept: got %h want 12345678", dut.ram.ram[64]); end
        vectors++;
        if (dut.cpu.rf[1] !== 32'h0) begin miscompares++; $display("FAIL mid_regs_cleared: got %h want 00000000", dut.cpu.rf[1]); end
        @(negedge clk);
        vectors++;
        if (dut.cpu.pc !== 32'h4) begin miscompares++; $display("FAIL mid_restart: got %h want 00000004", dut.cpu.pc); end
    endtask

    task automatic test_wrap();
        begin_test();
        dut.ram.ram[0]  = 32'h00001237;  // lui  x4,0x1
        dut.ram.ram[1]  = 32'h10022103;  // lw   x2,0x100(x4)
        dut.ram.ram[2]  = 32'h10002183;  // lw   x3,0x100(x0)
        dut.ram.ram[3]  = 32'h00310463;  // beq  x2,x3,+8
        dut.ram.ram[4]  = ASSERT_FAIL;
        dut.ram.ram[5]  = ASSERT_SUCCESS;
        dut.ram.ram[64] = 32'hCAFEF00D;
        release_reset();
        @(negedge clk);
        vectors++;
        if (probe.d_addr !== 32'h0000_1100) begin miscompares++; $display("FAIL wrap_addr: got %h want 00001100", probe.d_addr); end
        vectors++;
        if (probe.d_read !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wrap_read: got %h want cafef00d", probe.d_read); end
        repeat (4) @(negedge clk);
        vectors++;
        if (dut.cpu.rf[2] !== 32'hCAFEF00D || dut.cpu.rf[3] !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL wrap_regs: got %h %h want cafef00d cafef00d", dut.cpu.rf[2], dut.cpu.rf[3]);
        end
        vectors++;
        if (probe.i_read !== 32'h1) begin miscompares++; $display("FAIL wrap_pass: got %h want 00000001", probe.i_read); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_store_load();
        test_byte_store();
        test_reset_midrun();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/top.md
Name: top

Overview:
- Top-level integration of the single-core RV32I processor and its unified instruction/data memory.
- Contains the existing core (instance `cpu`, which holds the program counter `pc`) and a word-organised RAM (instance `ram`, storage array `ram`).
- Exposes only clock and reset. Program images are loaded hierarchically into `ram.ram` before reset is released.
- Simulation convention:
  - Fetched word 0x00000001 = test pass.
  - Fetched word 0x00000000 = test fail.

Parameters:
- RAM_WORD_CNT, default 1024 (from the shared constants), number of 32-bit words in the unified RAM.
- RESET_PC, default 32'h0000_0000, first fetch address after reset (passed to the core).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Internal nets, names fixed so that benches can probe them:
  - i_addr[31:0]: core to RAM, instruction address (= cpu.pc).
  - i_read[31:0]: RAM to core, fetched instruction word.
  - d_addr[31:0], d_write[31:0], d_we, d_mask[3:0]: core to RAM.
  - d_read[31:0]: RAM to core.
- Word index = addr[IDX_W+1:2], where IDX_W = clog2(RAM_WORD_CNT).
  - Upper address bits are ignored, so the RAM aliases/wraps across the 32-bit address space.
  - addr[1:0] is ignored for indexing.
- Instruction port: asynchronous read. i_read = ram[i_addr index] in the same cycle.
- Data read port: asynchronous read. d_read = ram[d_addr index] in the same cycle. The full word is returned; the core extracts bytes and halfwords.
- Data write port: synchronous, on posedge clk when d_we=1.
  - Byte lane k (bits 8k+7:8k) is written only if d_mask[k]=1.
  - The core supplies d_write already shifted into the correct lanes.
  - d_mask=4'b0000 with d_we=1 writes nothing.
- Read-during-write to the same word: both read ports return the old contents in that cycle. The new value is visible from the next cycle.
- Reset:
  - While reset=1 at a posedge, cpu.pc is loaded with RESET_PC and all core architectural state is cleared to the core's defined reset values.
  - The core must hold d_we=0 during reset.
  - RAM contents are NOT cleared by reset; a preloaded image survives reset and a reset mid-run.
- After reset deasserts, the first fetch is ram[RESET_PC index], visible on i_read in the first cycle with reset=0.
- Reset asserted mid-operation: the next posedge restarts from RESET_PC. Memory keeps any stores already committed.
- The words 0x00000000 and 0x00000001 are not decoded specially by the hardware. The core treats them as illegal instructions, with core-defined behaviour. The top must simply present them on i_read.
- No X must appear on i_read once RAM is initialised.

Decomposition:
- Shared constants package/header holds:
  - RAM_WORD_CNT
  - RESET_PC
  - test-status message constants (ASSERT_SUCCESS, ASSERT_FAIL, ASSERT_TIMEOUT, ASSERT_DEBUG_STOP)
  - opcode/funct constants used by the core
- One natural sub-module: `ram`, a dual-port memory with one asynchronous read-only port and one asynchronous-read/synchronous-byte-write port, parameterised by word count.
  - Instantiate it as `ram`, with internal array `ram`.
- The core is the existing `cpu` module, instantiated as `cpu`.

Test Plan:
- Preload ram[0]=0x00000001, pulse reset for one cycle -> i_read==0x00000001 in the first cycle after reset; bench reports pass.
- Preload `addi x1,x0,5; addi x2,x1,-5; beq x2,x0,+8; 0x00000000; 0x00000001` -> pc 0x0,0x4,0x8,0x10; i_read reaches 0x00000001 and never fetches the fail word.
- Store then load: preload `li x1,0x12345678; sw x1,0x100(x0); lw x2,0x100(x0)`, then check x2 via a branch to the pass/fail word -> ram[64]==0x12345678 after the store cycle; pass.
- Byte-lane store: ram[64]=0xFFFFFFFF preloaded, execute `sb x0,0x101(x0)` -> ram[64]==0xFFFF00FF; the other words are unchanged.
- Reset mid-run: assert reset after 10 cycles for 1 cycle -> pc==0x0 at the next edge, and the stored word from the earlier sw persists.
- Address wrap: load from address RAM_WORD_CNT*4+0x100 -> returns the same data as address 0x100.
